// File: rtl/binarize_pack.sv
// rtl/binarize_pack.sv - threshold binarization and bit packing into activation vectors
module binarize_pack #(
    parameter int pop_size    = 576,
    parameter int result_size = 10,
    parameter int count_size  = $clog2(pop_size + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [result_size-1:0] in_pop,
    input  logic [result_size-1:0] in_th,
    input  logic                   in_neg,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [pop_size-1:0]    out_act,
    output logic [count_size-1:0]  out_count
);

    localparam int ptr_w = (pop_size > 1) ? $clog2(pop_size) : 1;
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(pop_size - 1);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ptr_w-1:0]      ptr_q, ptr_d;
    logic [pop_size-1:0]   fill_q, fill_d;
    logic [pop_size-1:0]   act_q, act_d;
    logic [count_size-1:0] count_q, count_d;

    logic                  accept;
    logic                  act_bit;
    logic                  complete;
    logic [pop_size-1:0]   fill_new;

    assign in_ready  = (state_q == S_EMPTY) | out_ready;
    assign out_valid = (state_q == S_FULL);
    assign out_act   = act_q;
    assign out_count = count_q;

    always_comb begin
        accept   = in_valid & in_ready;
        // A negative folded scale flips the sense of the threshold compare.
        act_bit  = in_neg ? (in_pop < in_th) : (in_pop >= in_th);
        fill_new = fill_q;
        fill_new[ptr_q] = act_bit;
        complete = accept & ((ptr_q == ptr_last) | in_last);
    end

    always_comb begin
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        act_d   = act_q;
        count_d = count_q;
        if (complete) begin
            act_d   = fill_new;
            count_d = count_size'(ptr_q) + count_size'(1);
            ptr_d   = '0;
            fill_d  = '0;
        end else if (accept) begin
            fill_d = fill_new;
            ptr_d  = ptr_q + ptr_w'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (complete) state_d = S_FULL;
            S_FULL:  if (out_ready && !complete) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            fill_q  <= '0;
            act_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            act_q   <= act_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/binarize_pack.md
# binarize_pack

Binarization and packing stage for the binarized datapath. It takes one XNOR-popcount result per output neuron and compares it against a folded batch-norm threshold to produce one activation bit. It packs consecutive bits into a `pop_size`-wide activation vector that feeds the `a` input of the next layer's XNOR-popcount block. Input and output use valid/ready handshakes, and one completed vector is buffered at the output.

## Interface
Parameters:
- `pop_size`, 576, width of the packed activation vector (neurons per output vector).
- `result_size`, 10, width of the incoming popcount and threshold (`$clog2(pop_size)` of the upstream layer).
- `count_size`, `$clog2(pop_size+1)`, width of `out_count`.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  input beat valid.
- `in_ready`  output  1  block can accept a beat.
- `in_pop`  input  `result_size`  popcount of one neuron, unsigned.
- `in_th`  input  `result_size`  threshold for that neuron, unsigned.
- `in_neg`  input  1  folded batch-norm scale is negative; inverts the comparison.
- `in_last`  input  1  last neuron of the layer; flushes a partial vector.
- `out_valid`  output  1  packed vector available.
- `out_ready`  input  1  downstream accepts the vector.
- `out_act`  output  `pop_size`  packed activations; bit i is the i-th neuron of the vector.
- `out_count`  output  `count_size`  number of valid bits in `out_act` (1..`pop_size`).

## Operation
- **Beat acceptance:** a beat is accepted when `in_valid & in_ready` is true at a rising edge.
- **Bit computation:** bit = `in_neg` ? (`in_pop` < `in_th`) : (`in_pop` >= `in_th`). The compare is unsigned and full width, with no saturation.
- **Fill buffer:** a `pop_size`-bit register plus a fill pointer `ptr` (0..`pop_size`-1). An accepted bit is written to `fill[ptr]` and `ptr` increments.
- **Completion:** a beat completes the vector when `ptr == pop_size-1` or `in_last == 1`. On completion:
  - `out_act` is loaded with the fill contents including the new bit; bits at index > final `ptr` are 0.
  - `out_count` is loaded with `ptr+1`.
  - `out_valid` is set.
  - `ptr` and the fill buffer are cleared.
- **Simultaneous full and last:** `in_last` on the beat at `ptr == pop_size-1` produces a single vector with `out_count = pop_size`. No empty vector follows.
- **Output register:** single entry.
  - `out_act` and `out_count` hold stable while `out_valid & !out_ready`.
  - An `out_valid & out_ready` handshake clears `out_valid`, unless a completion occurs in the same cycle. In that case the new vector loads and `out_valid` stays 1.
- **Input ready:** `in_ready = !out_valid | out_ready`. This is a combinational path from `out_ready`, and it is permitted. Partial fills therefore also stall while the output is held.
- **State machine:** two states.
  - EMPTY (`out_valid = 0`) → FULL on completion.
  - FULL → EMPTY on output handshake without completion.
  - FULL → FULL on handshake with completion, or with no handshake.
- **Reset:** `rst` discards partial fills and held vectors. After reset, `ptr = 0`, fill = 0, `out_valid = 0`, `out_act = 0`, `out_count = 0`, and `in_ready = 1`.

## Timing
- A completion beat accepted at edge N gives `out_valid = 1` with the new data after edge N, i.e. a latency of 1 cycle.
- Throughput is one beat per cycle while downstream keeps `out_ready = 1`. There are no bubbles between vectors.
- Non-completing beats produce no output change.
- `rst` takes priority over any handshake in the same cycle.
- `in_ready` is 1 in the first cycle after `rst` deasserts.

## Test plan
All scenarios use an instance with `pop_size = 8`, `result_size = 4`.
- Full vector: 8 beats with `in_pop = 5`, `in_th = 5`, `in_neg = 0`, `out_ready = 1` held → one cycle after beat 8, `out_valid = 1`, `out_act = 8'hFF`, `out_count = 8`.
- Alternating pattern: `in_th = 4` on all beats, `in_pop` alternating 3, 4, 3, 4… → `out_act = 8'hAA`, `out_count = 8`.
- Negated compare with early flush: 3 beats with `in_neg = 1`, `in_pop = 2`, `in_th = 4`, `in_last = 1` on beat 3 → `out_act = 8'h07`, `out_count = 3`, `ptr` back to 0.
- Backpressure:
  - Complete one vector with `out_ready = 0` → `in_ready = 0`; `out_act` and `out_count` stay stable for 10 cycles.
  - Raise `out_ready` → handshake occurs, and the next beat is accepted in the same cycle.
  - Complete the next vector while draining → `out_valid` never drops.
- Extremes: `in_pop = 15`, `in_th = 0` → bit 1; `in_pop = 0`, `in_th = 15` → bit 0; `in_pop = 0`, `in_th = 0` → bit 1. Repeat each with `in_neg = 1` → bits 0, 1, 0 respectively.
- Reset mid-fill: assert `rst` after 4 accepted beats → all outputs are 0 the next cycle. The following 8 beats (all 1) give `out_act = 8'hFF` with no residue from before reset.
